// File: rtl/bsg_mcl_rx_pkt_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mcl_rx_pkt_serializer
// Purpose  : Buffers wide upstream packets in a small circular buffer and
//            serializes each one into 32-bit words for the AXI-Lite rx FIFO
//            read port. Word 0 (the packet LSBs) is delivered first.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   pkt_width_p   packet width in bits (multiple of 32, >= 64)
//   els_p         packet buffer depth (power of two, >= 2)
// Ports
//   clk_i         single clock
//   reset_i       synchronous active-high reset
//   pkt_v_i       upstream packet valid
//   pkt_i         upstream packet
//   pkt_ready_o   buffer can accept a packet (no bypass when full)
//   rx_v_o        a 32-bit word is available
//   rx_data_o     current 32-bit word
//   rx_ready_i    downstream consumes the current word
//   words_avail_o count of unread 32-bit words
//   stall_cnt_o   count of upstream stall cycles
// Configuration
//   BSG_MCL_RX_STALL_CNT_EN  when defined, builds a saturating 32-bit counter
//                            of cycles with pkt_v_i=1 and pkt_ready_o=0;
//                            otherwise stall_cnt_o is tied to zero.
// ============================================================================
module bsg_mcl_rx_pkt_serializer #(
  parameter int pkt_width_p = 128,
  parameter int els_p       = 4,
  localparam int words_lp     = pkt_width_p / 32,
  localparam int cnt_width_lp = $clog2(els_p * words_lp + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    pkt_v_i,
  input  logic [pkt_width_p-1:0]  pkt_i,
  output logic                    pkt_ready_o,
  output logic                    rx_v_o,
  output logic [31:0]             rx_data_o,
  input  logic                    rx_ready_i,
  output logic [cnt_width_lp-1:0] words_avail_o,
  output logic [31:0]             stall_cnt_o
);

  localparam int ptr_width_lp  = $clog2(els_p);
  localparam int pcnt_width_lp = $clog2(els_p + 1);
  localparam int widx_width_lp = $clog2(words_lp);

  localparam logic [widx_width_lp-1:0] last_widx_lp = widx_width_lp'(words_lp - 1);
  localparam logic [pcnt_width_lp-1:0] full_cnt_lp  = pcnt_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0]  ptr_one_lp   = ptr_width_lp'(1);
  localparam logic [widx_width_lp-1:0] widx_one_lp  = widx_width_lp'(1);
  localparam logic [pcnt_width_lp-1:0] pcnt_one_lp  = pcnt_width_lp'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  if ((pkt_width_p % 32) != 0 || pkt_width_p < 64) begin : g_bad_width
    $error("pkt_width_p must be a multiple of 32 and at least 64");
  end

  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $error("els_p must be a power of two and at least 2");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [pkt_width_p-1:0]   mem [els_p];
  logic [ptr_width_lp-1:0]  head;
  logic [ptr_width_lp-1:0]  tail;
  logic [pcnt_width_lp-1:0] pkt_cnt;
  logic [widx_width_lp-1:0] widx;

  logic enq;
  logic deq_word;
  logic deq_pkt;

  // Both valid/ready outputs come purely from registered state, so there is
  // no combinational path from pkt_v_i to rx_v_o and no full-buffer bypass.
  assign pkt_ready_o = (pkt_cnt != full_cnt_lp);
  assign rx_v_o      = (pkt_cnt != '0);

  assign enq      = pkt_v_i & pkt_ready_o;
  assign deq_word = rx_v_o & rx_ready_i;
  assign deq_pkt  = deq_word & (widx == last_widx_lp);

  // --------------------------------------------------------------------------
  // Packet storage (intentionally not reset; occupancy is tracked by pkt_cnt)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) begin
      mem[tail] <= pkt_i;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and word index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tail <= '0;
    end else if (enq) begin
      // els_p is a power of two, so the natural wrap is the modulo.
      tail <= tail + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head <= '0;
      widx <= '0;
    end else if (deq_word) begin
      if (widx == last_widx_lp) begin
        widx <= '0;
        head <= head + ptr_one_lp;
      end else begin
        widx <= widx + widx_one_lp;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_cnt <= '0;
    end else begin
      case ({enq, deq_pkt})
        2'b10:   pkt_cnt <= pkt_cnt + pcnt_one_lp;
        2'b01:   pkt_cnt <= pkt_cnt - pcnt_one_lp;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word selection from the head packet
  // --------------------------------------------------------------------------
  logic [pkt_width_p-1:0] head_pkt;
  logic [31:0]            head_words [words_lp];

  assign head_pkt = mem[head];

  for (genvar i = 0; i < words_lp; i++) begin : g_words
    assign head_words[i] = head_pkt[i*32 +: 32];
  end

  // Selection depends only on head and widx, which move only on a word
  // handshake, so the word holds steady while the consumer stalls.
  assign rx_data_o = head_words[widx];

  // --------------------------------------------------------------------------
  // Unread word count for the monitor register
  // --------------------------------------------------------------------------
  assign words_avail_o = cnt_width_lp'(pkt_cnt) * cnt_width_lp'(words_lp)
                       - cnt_width_lp'(widx);

  // --------------------------------------------------------------------------
  // Optional upstream stall counter
  // --------------------------------------------------------------------------
`ifdef BSG_MCL_RX_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt <= '0;
    end else if (pkt_v_i && !pkt_ready_o && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mcl_rx_pkt_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_mcl_rx_pkt_serializer
// Purpose  : Self-checking bench for bsg_mcl_rx_pkt_serializer using a
//            packet-queue reference model plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_mcl_rx_pkt_serializer;

  localparam int ELS   = 4;
  localparam int WORDS = 4;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         pkt_v_i;
  logic [127:0] pkt_i;
  logic         pkt_ready_o;
  logic         rx_v_o;
  logic [31:0]  rx_data_o;
  logic         rx_ready_i;
  logic [4:0]   words_avail_o;
  logic [31:0]  stall_cnt_o;

  always #5 clk = ~clk;

  bsg_mcl_rx_pkt_serializer #(
    .pkt_width_p (128),
    .els_p       (ELS)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .pkt_v_i       (pkt_v_i),
    .pkt_i         (pkt_i),
    .pkt_ready_o   (pkt_ready_o),
    .rx_v_o        (rx_v_o),
    .rx_data_o     (rx_data_o),
    .rx_ready_i    (rx_ready_i),
    .words_avail_o (words_avail_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of whole packets plus the offset of the next
  // unread word within the oldest packet.
  // --------------------------------------------------------------------------
  logic [127:0] mq [$];
  int           moff   = 0;
  logic [31:0]  mstall = 0;
  bit           seen   = 0;

  always @(posedge clk) begin : model_p
    bit full;
    bit empty;
    full  = (mq.size() == ELS);
    empty = (mq.size() == 0);
    if (reset_i) begin
      mq.delete();
      moff   = 0;
      mstall = 0;
      seen   = 1;
    end else begin
`ifdef BSG_MCL_RX_STALL_CNT_EN
      if (pkt_v_i && full && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
`endif
      if (!empty && rx_ready_i) begin
        moff++;
        if (moff == WORDS) begin
          moff = 0;
          void'(mq.pop_front());
        end
      end
      if (pkt_v_i && !full) mq.push_back(pkt_i);
    end
  end

  // One compare process, on the falling edge, every cycle after reset.
  always @(negedge clk) begin : cmp_p
    logic [127:0] hp;
    if (seen) begin
      chk("pkt_ready", {31'b0, pkt_ready_o}, {31'b0, mq.size() != ELS});
      chk("rx_v", {31'b0, rx_v_o}, {31'b0, mq.size() != 0});
      chk("words_avail", {27'b0, words_avail_o}, 32'(mq.size() * WORDS - moff));
      chk("stall_cnt", stall_cnt_o, mstall);
      if (mq.size() != 0) begin
        hp = mq[0];
        chk("rx_data", rx_data_o, hp[moff*32 +: 32]);
      end
      if (!reset_i && rx_v_o === 1'b1 && rx_ready_i === 1'b1) hs_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input int k);
    logic [127:0] p;
    for (int j = 0; j < WORDS; j++) p[j*32 +: 32] = 32'hD000_0000 | (k << 20) | j;
    return p;
  endfunction

  logic [31:0]  exp_w [4];
  logic [127:0] bp_pk [20];
  logic         rdy;
  int           sent;
  int           cyc;

  initial begin
    reset_i    = 1'b1;
    pkt_v_i    = 1'b0;
    pkt_i      = '0;
    rx_ready_i = 1'b0;
    repeat (3) step();

    // Reset state, observed while reset is still held.
    at_neg();
    chk("rst_rx_v", {31'b0, rx_v_o}, 32'd0);
    chk("rst_pkt_ready", {31'b0, pkt_ready_o}, 32'd1);
    chk("rst_words_avail", {27'b0, words_avail_o}, 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    step();
    reset_i = 1'b0;

    // Single packet, consumer always ready.
    exp_w[0] = 32'h1111_1111;
    exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333;
    exp_w[3] = 32'h4444_4444;
    pkt_v_i    = 1'b1;
    pkt_i      = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    rx_ready_i = 1'b1;
    step();
    pkt_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("single_v", {31'b0, rx_v_o}, 32'd1);
      chk("single_data", rx_data_o, exp_w[i]);
      chk("single_avail", {27'b0, words_avail_o}, 32'(4 - i));
      step();
    end
    at_neg();
    chk("single_end_v", {31'b0, rx_v_o}, 32'd0);
    chk("single_end_avail", {27'b0, words_avail_o}, 32'd0);

    // Fill to full with the consumer stalled; 5th packet is held off.
    rx_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pkt_v_i = 1'b1;
      pkt_i   = mk(k);
      step();
    end
    at_neg();
    chk("full_ready", {31'b0, pkt_ready_o}, 32'd0);
    chk("full_avail", {27'b0, words_avail_o}, 32'd16);
    chk("full_data", rx_data_o, 32'hD000_0000);
`ifndef BSG_MCL_RX_STALL_CNT_EN
    chk("full_stall_off", stall_cnt_o, 32'd0);
`endif
    repeat (3) step();

    // Drain exactly one packet while the upstream keeps offering: no
    // enqueue on the last-word cycle, enqueue on the next.
    rx_ready_i = 1'b1;
    repeat (4) step();
    rx_ready_i = 1'b0;
    at_neg();
    chk("simul_ready", {31'b0, pkt_ready_o}, 32'd1);
    chk("simul_avail", {27'b0, words_avail_o}, 32'd12);
    chk("simul_data", rx_data_o, 32'hD010_0000);
    step();
    pkt_v_i = 1'b0;
    at_neg();
    chk("refill_ready", {31'b0, pkt_ready_o}, 32'd0);
    chk("refill_avail", {27'b0, words_avail_o}, 32'd16);
`ifndef BSG_MCL_RX_STALL_CNT_EN
    chk("refill_stall_off", stall_cnt_o, 32'd0);
`endif
    rx_ready_i = 1'b1;
    repeat (18) step();
    rx_ready_i = 1'b0;
    at_neg();
    chk("drain_v", {31'b0, rx_v_o}, 32'd0);
    chk("drain_avail", {27'b0, words_avail_o}, 32'd0);

    // Random backpressure on both sides over 20 packets.
    for (int k = 0; k < 20; k++)
      bp_pk[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    hs_cnt = 0;
    sent   = 0;
    cyc    = 0;
    while (sent < 20 && cyc < 3000) begin
      rdy        = pkt_ready_o;
      pkt_v_i    = 1'($urandom_range(0, 1));
      pkt_i      = bp_pk[sent];
      rx_ready_i = 1'($urandom_range(0, 1));
      step();
      cyc++;
      if (pkt_v_i && rdy) sent++;
    end
    pkt_v_i = 1'b0;
    while (mq.size() != 0 && cyc < 3000) begin
      rx_ready_i = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    rx_ready_i = 1'b0;
    chk("bp_in_budget", {31'b0, cyc < 3000}, 32'd1);
    chk("bp_words", 32'(hs_cnt), 32'd80);

    // Reset after two of four words consumed.
    pkt_v_i = 1'b1;
    pkt_i   = 128'hAAAA_0004_AAAA_0003_AAAA_0002_AAAA_0001;
    step();
    pkt_v_i    = 1'b0;
    rx_ready_i = 1'b1;
    step();
    step();
    reset_i    = 1'b1;
    pkt_v_i    = 1'b1;
    pkt_i      = 128'hBBBB_0004_BBBB_0003_BBBB_0002_BBBB_0001;
    step();
    reset_i    = 1'b0;
    pkt_v_i    = 1'b0;
    rx_ready_i = 1'b0;
    at_neg();
    chk("midrst_v", {31'b0, rx_v_o}, 32'd0);
    chk("midrst_avail", {27'b0, words_avail_o}, 32'd0);
    chk("midrst_ready", {31'b0, pkt_ready_o}, 32'd1);
    pkt_v_i = 1'b1;
    pkt_i   = 128'h5555_0004_5555_0003_5555_0002_5555_0001;
    step();
    pkt_v_i = 1'b0;
    at_neg();
    chk("post_rst_data", rx_data_o, 32'h5555_0001);
    chk("post_rst_avail", {27'b0, words_avail_o}, 32'd4);
    rx_ready_i = 1'b1;
    repeat (5) step();
    rx_ready_i = 1'b0;
    at_neg();
    chk("post_rst_empty", {31'b0, rx_v_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_mcl_rx_pkt_serializer.md
BSG_MCL_RX_PKT_SERIALIZER -- requirements
Module: bsg_mcl_rx_pkt_serializer

Interface
REQ-001 The block SHALL have parameter pkt_width_p, default 128, giving the packet width in bits; it SHALL be a multiple of 32 and at least 64.
REQ-002 The block SHALL have parameter els_p, default 4, giving the packet buffer depth; it SHALL be a power of two and at least 2.
REQ-003 Derived value words_lp = pkt_width_p/32; cnt_width_lp = clog2(els_p*words_lp+1).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port pkt_v_i, input, 1 bit: upstream packet valid.
REQ-007 The block SHALL have port pkt_i, input, pkt_width_p bits: upstream packet.
REQ-008 The block SHALL have port pkt_ready_o, output, 1 bit: packet accepted when pkt_v_i & pkt_ready_o.
REQ-009 The block SHALL have port rx_v_o, output, 1 bit: 32-bit word valid toward the AXI-Lite rx FIFO read port.
REQ-010 The block SHALL have port rx_data_o, output, 32 bits: the current word.
REQ-011 The block SHALL have port rx_ready_i, input, 1 bit: word consumed when rx_v_o & rx_ready_i.
REQ-012 The block SHALL have port words_avail_o, output, cnt_width_lp bits: count of unread 32-bit words, for the monitor register.
REQ-013 The block SHALL have port stall_cnt_o, output, 32 bits: count of upstream stall cycles (see Configuration).

Function
REQ-014 The block SHALL hold packets in a circular buffer with head pointer, tail pointer, packet count pkt_cnt (0..els_p) and word index widx (0..words_lp-1).
REQ-015 pkt_ready_o SHALL equal (pkt_cnt != els_p); there SHALL be no bypass, so pkt_ready_o is 0 when the buffer is full even if a dequeue occurs in the same cycle.
REQ-016 On enqueue, pkt_i SHALL be written at tail, and tail SHALL increment modulo els_p.
REQ-017 rx_v_o SHALL equal (pkt_cnt != 0) and SHALL be registered-state driven, with no combinational path from pkt_v_i.
REQ-018 rx_data_o SHALL equal buf[head][widx*32 +: 32], so word 0 is the LSBs and is sent first.
REQ-019 On each word handshake with widx < words_lp-1, widx SHALL increment.
REQ-020 On a word handshake with widx == words_lp-1, widx SHALL go to 0, head SHALL increment modulo els_p, and pkt_cnt SHALL decrement.
REQ-021 On a simultaneous enqueue and last-word dequeue, pkt_cnt SHALL be unchanged.
REQ-022 First-word latency SHALL be 1 cycle: a packet accepted in cycle N gives rx_v_o=1 in cycle N+1.
REQ-023 words_avail_o SHALL equal pkt_cnt*words_lp - widx, computed combinationally from registered state.
REQ-024 rx_data_o SHALL hold stable while rx_v_o=1 and rx_ready_i=0.
REQ-025 When rx_v_o=0, rx_data_o is don't-care, and rx_ready_i SHALL be ignored.

Reset
REQ-026 While reset_i=1 at the clock edge, head, tail, pkt_cnt, widx and the stall counter SHALL clear to 0.
REQ-027 During and after reset, outputs SHALL be: rx_v_o=0, pkt_ready_o=1, words_avail_o=0, stall_cnt_o=0.
REQ-028 Buffer storage SHALL NOT be reset.
REQ-029 A reset in the middle of a packet SHALL discard all buffered words, and no partial packet SHALL resume.
REQ-030 Handshakes presented in a reset cycle SHALL be ignored.

Configuration
REQ-031 With macro BSG_MCL_RX_STALL_CNT_EN defined, a 32-bit counter SHALL increment each cycle in which pkt_v_i=1 and pkt_ready_o=0, saturating at 32'hFFFF_FFFF, and stall_cnt_o SHALL output the counter.
REQ-032 With BSG_MCL_RX_STALL_CNT_EN undefined, no counter flops SHALL exist and stall_cnt_o SHALL be tied to 32'h0.

Verification
REQ-033 Single packet: reset, send pkt 128'h4444_4444_3333_3333_2222_2222_1111_1111 with rx_ready_i=1 -> words 1111_1111, 2222_2222, 3333_3333, 4444_4444 appear on consecutive cycles starting 1 cycle later; words_avail_o reads 4,3,2,1,0.
REQ-034 Fill/full: send 5 packets with rx_ready_i=0 -> 4 accepted, pkt_ready_o=0 after the 4th, words_avail_o=16; with the macro enabled, stall_cnt_o increments each held cycle.
REQ-035 Simultaneous events: buffer full and last word consumed in cycle N with pkt_v_i=1 -> no enqueue in cycle N, enqueue in N+1, pkt_cnt=4 again.
REQ-036 Backpressure: toggle rx_ready_i randomly over 20 packets -> rx_data_o stable while stalled, all 80 words delivered in order, pointers wrap correctly through index 3 to 0.
REQ-037 Reset mid-packet: assert reset_i after 2 of 4 words are consumed -> next cycle rx_v_o=0 and words_avail_o=0; a new packet then starts at word 0.
REQ-038 Macro off: drive the stall pattern of REQ-034 -> stall_cnt_o=0 throughout.
